// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the up/down counter slice.
//   CNT_W     : default counter width in bits.
//   cnt_t     : count value type at the default width.
//   DIR_UP    : sel encoding for counting up.
//   DIR_DOWN  : sel encoding for counting down.
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/updown_counter_core.sv
// ---------------------------------------------------------------------------
// updown_counter_core
//   Free-running WIDTH-bit up/down counter that wraps modulo 2**WIDTH.
//   Synchronous, active-high reset takes priority over the direction select.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      synchronous reset, 1 = clear count to 0
//     sel    in   1      direction, DIR_UP = +1, DIR_DOWN = -1
//     count  out  WIDTH  registered count value
// ---------------------------------------------------------------------------
module updown_counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next-state mux: reset, then +1 / -1. Unsigned WIDTH-bit arithmetic
    // wraps naturally at both ends, so no explicit wrap handling is needed.
    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (sel == DIR_UP) begin
            count_d = count_q + STEP;
        end else begin
            count_d = count_q - STEP;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule : updown_counter_core

// File: rtl/synth_wrapper.sv
// ---------------------------------------------------------------------------
// synth_wrapper
//   Synthesis top for the WIDTH-bit up/down counter. Pure port mapping
//   around updown_counter_core; out comes straight from the count register.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      synchronous reset, ACTIVE HIGH despite the _n name
//                        (1 = reset)
//     sel    in   1      direction, 1 = count up, 0 = count down
//     out    out  WIDTH  current count
// ---------------------------------------------------------------------------
module synth_wrapper
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    updown_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst_n),
        .sel   (sel),
        .count (out)
    );

endmodule : synth_wrapper

// File: tb/tb_synth_wrapper.sv
// ---------------------------------------------------------------------------
// tb_synth_wrapper
//   Self-checking bench for synth_wrapper (WIDTH = 4).
//   Directed vector table, hand-written latency sequences, and a random
//   run checked against a modulo-16 reference model through exp_q.
// ---------------------------------------------------------------------------
module tb_synth_wrapper;

    localparam int W = 4;

    typedef struct {
        logic         rst;
        logic         sel;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic [W-1:0] out;

    int n_cmp;
    int n_err;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];

    synth_wrapper #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .out   (out)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b1;
        sel   = 1'b0;
    end

    // ------------------------------------------------------------------
    // Driver tasks: inputs change 1 time unit after a rising edge, outputs
    // are sampled 1 time unit after the next rising edge.
    // ------------------------------------------------------------------
    task automatic drive_cycle(input logic r, input logic s);
        rst_n = r;
        sel   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic s, input logic [W-1:0] e,
                           input string name);
        vec_t v;
        v.rst  = r;
        v.sel  = s;
        v.exp  = e;
        v.name = name;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Main test
    // ------------------------------------------------------------------
    initial begin : main
        logic [W-1:0] model;
        logic [W-1:0] prev;
        logic [W-1:0] exp_v;
        logic         s;
        logic         jump_ok;

        n_cmp = 0;
        n_err = 0;

        // Reset hold: two reset edges with differing sel
        add_vec(1'b1, 1'b1, 4'h0, "rst_hold_0");
        add_vec(1'b1, 1'b0, 4'h0, "rst_hold_1");
        // Up count through the 15 -> 0 wrap
        add_vec(1'b1, 1'b0, 4'h0, "up_rst");
        for (int i = 1; i <= 17; i++) begin
            add_vec(1'b0, 1'b1, 4'(i % 16), "up_count");
        end
        // Down count through the 0 -> 15 wrap
        add_vec(1'b1, 1'b1, 4'h0, "dn_rst");
        add_vec(1'b0, 1'b0, 4'hF, "dn_wrap");
        add_vec(1'b0, 1'b0, 4'hE, "dn_count");
        add_vec(1'b0, 1'b0, 4'hD, "dn_count");
        // Direction change
        add_vec(1'b1, 1'b0, 4'h0, "dir_rst");
        for (int i = 1; i <= 5; i++) begin
            add_vec(1'b0, 1'b1, 4'(i), "dir_up");
        end
        add_vec(1'b0, 1'b0, 4'h4, "dir_down");
        add_vec(1'b0, 1'b0, 4'h3, "dir_down");
        // Reset mid-count, then resume from 0
        add_vec(1'b1, 1'b1, 4'h0, "mid_rst0");
        for (int i = 1; i <= 9; i++) begin
            add_vec(1'b0, 1'b1, 4'(i), "mid_up");
        end
        add_vec(1'b1, 1'b0, 4'h0, "mid_rst");
        add_vec(1'b0, 1'b1, 4'h1, "mid_resume");
        // Reset also wins over a down select mid-count
        add_vec(1'b0, 1'b0, 4'h0, "pre_rst_dn");
        add_vec(1'b0, 1'b0, 4'hF, "pre_rst_dn");
        add_vec(1'b1, 1'b0, 4'h0, "rst_over_dn");

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].rst, vecs[i].sel);
            check(vecs[i].name, out, vecs[i].exp);
        end

        // Latency: a sel change between edges must not reach out until
        // the next rising edge.
        drive_cycle(1'b1, 1'b0);
        check("lat_rst", out, 4'h0);
        rst_n = 1'b0;
        sel   = 1'b1;
        #2;
        check("lat_no_comb_up", out, 4'h0);
        sel = 1'b0;
        #2;
        check("lat_no_comb_dn", out, 4'h0);
        sel = 1'b1;
        @(posedge clk);
        #1;
        check("lat_step_up", out, 4'h1);
        sel = 1'b0;
        #3;
        check("lat_hold", out, 4'h1);
        @(posedge clk);
        #1;
        check("lat_step_dn", out, 4'h0);

        // Random direction run against a modulo-16 reference model
        drive_cycle(1'b1, 1'b0);
        check("rnd_rst", out, 4'h0);
        model = 4'h0;
        for (int i = 0; i < 100; i++) begin
            s = 1'($urandom_range(0, 1));
            model = s ? model + 4'h1 : model - 4'h1;
            exp_q.push_back(model);
            prev = out;
            drive_cycle(1'b0, s);
            exp_v = exp_q.pop_front();
            check("rnd_model", out, exp_v);
            // A 0<->15 jump is legal only as the matching wrap
            jump_ok = !((prev == 4'h0 && out == 4'hF && s) ||
                        (prev == 4'hF && out == 4'h0 && !s));
            check("rnd_wrap_dir", {3'b000, jump_ok}, 4'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_synth_wrapper
